// File: rtl/imem_stream_loader.sv
// ---------------------------------------------------------------------------
// imem_stream_loader
//   Instruction memory that answers the PC fetch interface combinationally.
//   A byte-stream loader (low byte first) fills the memory at run time and
//   holds the CPU while a load is in progress.
//
// Ports
//   clk, rst_n    rising-edge clock, asynchronous active-low reset
//   pc            fetch word address
//   instr         word at pc; NOP (0) when out of range or while cpu_hold=1
//   load_start    pulse: begin (or restart) a load at word 0
//   load_valid    load_byte valid this cycle
//   load_byte     program byte; even bytes -> [7:0], odd bytes -> [15:8]
//   load_ready    loader accepts a byte when load_valid && load_ready
//   load_end      pulse: last byte has been sent
//   load_done     pulse: load committed
//   load_err      sticky: a word was dropped because memory overflowed
//   word_count    words written by the current/last load (saturates at DEPTH)
//   cpu_hold      1 while loading; the PC must not advance
// ---------------------------------------------------------------------------
module imem_stream_loader #(
   parameter int BUS_WIDTH = 16,
   parameter int ADDR_BITS = 8
) (
   input  logic                 clk,
   input  logic                 rst_n,
   input  logic [BUS_WIDTH-1:0] pc,
   output logic [BUS_WIDTH-1:0] instr,
   input  logic                 load_start,
   input  logic                 load_valid,
   input  logic [7:0]           load_byte,
   output logic                 load_ready,
   input  logic                 load_end,
   output logic                 load_done,
   output logic                 load_err,
   output logic [ADDR_BITS:0]   word_count,
   output logic                 cpu_hold
);

   localparam int               DEPTH    = 2 ** ADDR_BITS;
   localparam logic [ADDR_BITS:0] ADDR_ONE = (ADDR_BITS + 1)'(1);

   typedef enum logic [1:0] {IDLE, RX_LO, RX_HI, COMMIT} state_t;

   state_t                 state, state_nxt;
   logic [BUS_WIDTH-1:0]   mem [DEPTH];
   logic [ADDR_BITS:0]     wr_addr;
   logic [7:0]             lo_byte;
   logic                   in_rx, restart, accept, mem_full;
   logic                   word_we;
   logic [BUS_WIDTH-1:0]   word_data;

   assign in_rx    = (state == RX_LO) || (state == RX_HI);
   // load_start wins over any byte or end arriving in the same cycle.
   assign restart  = load_start && ((state == IDLE) || in_rx);
   assign accept   = load_valid && in_rx && !load_start;
   // wr_addr saturates at DEPTH, so its top bit alone flags a full memory.
   assign mem_full = wr_addr[ADDR_BITS];

   // wr_addr and word_count always move together; one register serves both.
   assign word_count = wr_addr;

   // ---------------- state register ----------------
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state <= IDLE;
      else        state <= state_nxt;
   end

   // ---------------- next-state logic ----------------
   // NOTE: every always_comb output gets a default first so no latch is inferred.
   always_comb begin
      state_nxt = state;
      case (state)
         IDLE:   if (load_start) state_nxt = RX_LO;
         RX_LO: begin
            if (load_start)    state_nxt = RX_LO;
            else if (load_end) state_nxt = COMMIT;  // any same-cycle byte is padded
            else if (accept)   state_nxt = RX_HI;
         end
         RX_HI: begin
            if (load_start)    state_nxt = RX_LO;
            else if (load_end) state_nxt = COMMIT;  // completes or pads the word
            else if (accept)   state_nxt = RX_LO;
         end
         COMMIT: state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   // ---------------- outputs ----------------
   always_comb begin
      load_ready = 1'b0;
      load_done  = 1'b0;
      cpu_hold   = 1'b1;
      case (state)
         IDLE:   cpu_hold   = 1'b0;
         RX_LO:  load_ready = 1'b1;
         RX_HI:  load_ready = 1'b1;
         COMMIT: load_done  = 1'b1;
         default: cpu_hold  = 1'b0;
      endcase
   end

   // ---------------- word assembly ----------------
   // A word is produced when the high byte arrives, or when load_end leaves an
   // odd byte over (including a byte that arrives together with load_end).
   always_comb begin
      word_we   = 1'b0;
      word_data = BUS_WIDTH'({8'h00, lo_byte});
      case (state)
         RX_LO: if (accept && load_end) begin
            word_we   = 1'b1;
            word_data = BUS_WIDTH'({8'h00, load_byte});
         end
         RX_HI: begin
            if (accept) begin
               word_we   = 1'b1;
               word_data = BUS_WIDTH'({load_byte, lo_byte});
            end else if (load_end && !load_start) begin
               word_we   = 1'b1;
            end
         end
         default: ;
      endcase
   end

   // ---------------- loader datapath ----------------
   // NOTE: sequential state uses non-blocking assignments only.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wr_addr  <= '0;
         lo_byte  <= '0;
         load_err <= 1'b0;
      end else if (restart) begin
         wr_addr  <= '0;
         lo_byte  <= '0;
         load_err <= 1'b0;
      end else begin
         if (accept && (state == RX_LO)) lo_byte <= load_byte;
         if (word_we) begin
            if (mem_full) load_err <= 1'b1;
            else          wr_addr  <= wr_addr + ADDR_ONE;
         end
      end
   end

   // NOTE: the memory array has no reset; contents survive rst_n and restarts.
   always_ff @(posedge clk) begin
      if (word_we && !mem_full) mem[wr_addr[ADDR_BITS-1:0]] <= word_data;
   end

   // ---------------- combinational fetch ----------------
   always_comb begin
      instr = '0;
      if (!cpu_hold && (pc < BUS_WIDTH'(DEPTH))) instr = mem[pc[ADDR_BITS-1:0]];
   end

endmodule

// File: tb/tb_imem_stream_loader.sv
// ---------------------------------------------------------------------------
// tb_imem_stream_loader
//   Directed bench for imem_stream_loader. Two instances share all inputs:
//   a full-size one (ADDR_BITS=8) and a tiny one (ADDR_BITS=2) used for the
//   overflow scenario.
// ---------------------------------------------------------------------------
module tb_imem_stream_loader;

   logic        clk = 1'b0;
   logic        rst_n;
   logic [15:0] pc;
   logic        load_start, load_valid, load_end;
   logic [7:0]  load_byte;

   logic [15:0] instr,  s_instr;
   logic        ready,  s_ready;
   logic        done,   s_done;
   logic        err,    s_err;
   logic        hold,   s_hold;
   logic [8:0]  wc;
   logic [2:0]  s_wc;

   int n_vec = 0;
   int n_err = 0;

   always #5 clk = ~clk;

   imem_stream_loader #(.BUS_WIDTH(16), .ADDR_BITS(8)) dut (
      .clk(clk), .rst_n(rst_n), .pc(pc), .instr(instr),
      .load_start(load_start), .load_valid(load_valid), .load_byte(load_byte),
      .load_ready(ready), .load_end(load_end), .load_done(done),
      .load_err(err), .word_count(wc), .cpu_hold(hold)
   );

   imem_stream_loader #(.BUS_WIDTH(16), .ADDR_BITS(2)) dut_small (
      .clk(clk), .rst_n(rst_n), .pc(pc), .instr(s_instr),
      .load_start(load_start), .load_valid(load_valid), .load_byte(load_byte),
      .load_ready(s_ready), .load_end(load_end), .load_done(s_done),
      .load_err(s_err), .word_count(s_wc), .cpu_hold(s_hold)
   );

   task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
      n_vec++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   // Advance one clock; inputs change and outputs are sampled 1 ns after the edge.
   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic send_byte(input logic [7:0] b);
      load_valid = 1'b1;
      load_byte  = b;
      step();
      load_valid = 1'b0;
   endtask

   task automatic pulse_start();
      load_start = 1'b1;
      step();
      load_start = 1'b0;
   endtask

   task automatic pulse_end();
      load_end = 1'b1;
      step();
      load_end = 1'b0;
   endtask

   task automatic fetch(input logic [15:0] a);
      pc = a;
      #1;
   endtask

   initial begin
      #20000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1, "watchdog expired");
   end

   initial begin
      rst_n = 1'b0; pc = '0;
      load_start = 1'b0; load_valid = 1'b0; load_end = 1'b0; load_byte = '0;

      // ---- reset values ----
      #3;
      check("rst_ready", 16'(ready), 16'h0);
      check("rst_done",  16'(done),  16'h0);
      check("rst_err",   16'(err),   16'h0);
      check("rst_wc",    16'(wc),    16'h0);
      check("rst_hold",  16'(hold),  16'h0);
      #9 rst_n = 1'b1;
      step();

      // ---- 1: two full words ----
      pulse_start();
      check("t1_hold",      16'(hold),  16'h1);
      check("t1_ready",     16'(ready), 16'h1);
      check("t1_instr_nop", instr,      16'h0000);
      send_byte(8'h34); send_byte(8'h12); send_byte(8'h78); send_byte(8'h56);
      check("t1_wc_pre", 16'(wc), 16'h2);
      pulse_end();
      check("t1_done",      16'(done), 16'h1);
      check("t1_hold_cm",   16'(hold), 16'h1);
      check("t1_wc",        16'(wc),   16'h2);
      step();
      check("t1_done_once", 16'(done), 16'h0);
      check("t1_hold_rel",  16'(hold), 16'h0);
      fetch(16'd0); check("t1_mem0", instr, 16'h1234);
      fetch(16'd1); check("t1_mem1", instr, 16'h5678);

      // ---- 2: odd byte count is padded ----
      pulse_start();
      send_byte(8'hAA); send_byte(8'hBB); send_byte(8'hCC);
      pulse_end();
      check("t2_done", 16'(done), 16'h1);
      check("t2_wc",   16'(wc),   16'h2);
      step();
      fetch(16'd0); check("t2_mem0", instr, 16'hBBAA);
      fetch(16'd1); check("t2_mem1", instr, 16'h00CC);

      // ---- 3a: lone byte together with load_end ----
      pulse_start();
      load_valid = 1'b1; load_byte = 8'hCC; load_end = 1'b1;
      step();
      load_valid = 1'b0; load_end = 1'b0;
      check("t3a_done", 16'(done), 16'h1);
      check("t3a_wc",   16'(wc),   16'h1);
      step();
      fetch(16'd0); check("t3a_mem0", instr, 16'h00CC);

      // ---- 3b: high byte together with load_end ----
      pulse_start();
      send_byte(8'h11);
      load_valid = 1'b1; load_byte = 8'h22; load_end = 1'b1;
      step();
      load_valid = 1'b0; load_end = 1'b0;
      check("t3b_done", 16'(done), 16'h1);
      check("t3b_wc",   16'(wc),   16'h1);
      step();
      fetch(16'd0); check("t3b_mem0", instr, 16'h2211);

      // ---- 4: overflow on the 4-word instance ----
      pulse_start();
      for (int i = 1; i <= 10; i++) send_byte(8'(i));
      check("t4_s_err", 16'(s_err), 16'h1);
      check("t4_s_wc",  16'(s_wc),  16'h4);
      check("t4_err",   16'(err),   16'h0);
      check("t4_wc",    16'(wc),    16'h5);
      pulse_end();
      check("t4_s_done", 16'(s_done), 16'h1);
      step();
      check("t4_s_err_sticky", 16'(s_err), 16'h1);
      check("t4_s_wc_final",   16'(s_wc),  16'h4);
      fetch(16'd0);     check("t4_s_mem0",  s_instr, 16'h0201);
      fetch(16'd3);     check("t4_s_mem3",  s_instr, 16'h0807);
      fetch(16'd5);     check("t4_s_pc5",   s_instr, 16'h0000);
      fetch(16'd4);     check("t4_mem4",    instr,   16'h0A09);
      fetch(16'h0100);  check("t4_pc_oob",  instr,   16'h0000);

      // ---- 5: restart mid-load; start beats a same-cycle byte ----
      pulse_start();
      check("t5_s_err_clr", 16'(s_err), 16'h0);
      send_byte(8'h11); send_byte(8'h22); send_byte(8'h33);
      check("t5_wc_pre", 16'(wc), 16'h1);
      load_start = 1'b1; load_valid = 1'b1; load_byte = 8'h99;
      step();
      load_start = 1'b0; load_valid = 1'b0;
      check("t5_wc_restart", 16'(wc),   16'h0);
      check("t5_hold",       16'(hold), 16'h1);
      send_byte(8'h44); send_byte(8'h55);
      pulse_end();
      check("t5_done", 16'(done), 16'h1);
      check("t5_wc",   16'(wc),   16'h1);
      step();
      fetch(16'd0); check("t5_mem0", instr, 16'h5544);

      // ---- 6: asynchronous reset while in RX_HI ----
      pulse_start();
      send_byte(8'h77);
      rst_n = 1'b0;
      #1;
      check("t6_ready", 16'(ready), 16'h0);
      check("t6_hold",  16'(hold),  16'h0);
      check("t6_wc",    16'(wc),    16'h0);
      check("t6_done",  16'(done),  16'h0);
      @(negedge clk);
      rst_n = 1'b1;
      step();
      send_byte(8'h88); send_byte(8'h99);
      pulse_end();
      check("t6_ignored_wc",    16'(wc),    16'h0);
      check("t6_ignored_ready", 16'(ready), 16'h0);
      check("t6_ignored_done",  16'(done),  16'h0);
      fetch(16'd0); check("t6_mem0_kept", instr, 16'h5544);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
